button_event_ctrl: RTL and testbench
====================================

// Module: button_event_ctrl
// PURPOSE
//  Debounce controller for N push-buttons sharing one prescaler tick. Each input is
//  synchronized, then qualified by a per-button 4-state FSM. Qualified press/release
//  events are serialized onto one valid/ready event port by a round-robin arbiter.
//  Sits between the board button pins and the user-logic FSMs.
// PARAMETERS
//  N_BTN        4       number of buttons (>=2)
//  CLK_DIV      100000  clk cycles per sample tick (1 ms @ 100 MHz), >=2
//  STABLE_TICKS 10      consecutive stable ticks to accept a level change, >=1
// PORTS
//  clk        in   1                clock, all logic on posedge
//  rst_n      in   1                asynchronous, active-low reset
//  btn_in     in   N_BTN            raw asynchronous button pins, 1 = pressed
//  btn_level  out  N_BTN            debounced level per button
//  evt_valid  out  1                event available
//  evt_ready  in   1                consumer accepts event when valid&ready
//  evt_id     out  $clog2(N_BTN)    button index of event
//  evt_press  out  1                1 = press, 0 = release
//  evt_drop   out  1                1-cycle pulse: unserved pending event overwritten
// BEHAVIOUR
//  Reset (async, rst_n=0): sync FFs, prescaler, counters, FSMs=RELEASED, btn_level=0,
//   pending=0, evt_valid=0, evt_id=0, evt_press=0, evt_drop=0, rr pointer=0.
//   Reset mid-operation discards all pending and in-flight events.
//  Sync: 2-FF chain per bit; s[i] = btn_in[i] delayed 2 clk.
//  Prescaler: cnt 0..CLK_DIV-1, wraps; tick=1 for one cycle when cnt==CLK_DIV-1.
//  Per-button FSM, stab counter width $clog2(STABLE_TICKS+1):
//   RELEASED:    s=1 -> PRESS_CHK, stab=0.
//   PRESS_CHK:   s=0 (any cycle) -> RELEASED (bounce, no event); else on tick stab++;
//                tick with stab==STABLE_TICKS-1 -> PRESSED, btn_level=1, post press.
//   PRESSED:     s=0 -> RELEASE_CHK, stab=0.
//   RELEASE_CHK: s=1 -> PRESSED (no event); tick with stab==STABLE_TICKS-1 ->
//                RELEASED, btn_level=0, post release.
//   Sync is checked every clk; ticks only advance stab.
//  Pending: per-button pend bit + type. Post sets pend/type. Post while pend already
//   set and not loaded this cycle -> type overwritten, evt_drop=1 for that cycle.
//   Post in same cycle the arbiter loads that button's pend -> load takes old type,
//   pend stays set with new type, no drop.
//  Arbiter/output register: load allowed when !evt_valid or (evt_valid & evt_ready).
//   On load, pick first pend bit scanning (rr+1) mod N_BTN upward, wrap; drive
//   evt_id/evt_press, evt_valid=1, clear that pend bit, rr=picked index.
//   No pend on load slot -> evt_valid=0. evt_id/evt_press held stable while
//   valid & !ready. Back-to-back transfers allowed (one event per cycle).
//  Latency: btn_level rises 1 clk after qualifying tick; evt_valid earliest 1 clk later.
// TESTING (sim params N_BTN=4, CLK_DIV=4, STABLE_TICKS=3, evt_ready=1 unless stated)
//  1 Clean press: btn_in[2] 0->1, held -> btn_level[2]=1 after 3rd tick in PRESS_CHK;
//    next cycle evt_valid=1, evt_id=2, evt_press=1, for exactly 1 cycle.
//  2 Bounce: btn_in[0] toggles every 3 clk for 40 clk then stays 0 -> no event,
//    btn_level[0]=0 throughout; stays 1 for 12+ clk then drops -> press then release.
//  3 Simultaneous: btn 0,1,3 pressed same cycle, evt_ready=0 for 20 clk then 1 ->
//    evt_id held at 1 (rr=0 start) while stalled, then sequence 1,3,0 on consecutive cycles.
//  4 Overwrite: evt_ready=0, btn1 press then release qualify while btn0 event holds
//    output -> evt_drop pulses once; btn1 delivered once with evt_press=0.
//  5 Reset mid-op: rst_n=0 for 2 clk while evt_valid=1 and btn2 in PRESS_CHK ->
//    all outputs 0 immediately (async); held button re-qualifies after release of
//    reset and emits one press.

Source files
------------

// File: rtl/button_event_ctrl_if.sv
// Event port of the button controller: one serialized press/release event per handshake.
// The controller drives it through the master modport; the consumer uses the slave modport.
interface button_event_ctrl_if #(
    parameter int N_BTN = 4
) ();
    localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_id;
    logic          evt_press;
    logic          evt_drop;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_press,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_press,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Debounces N push-buttons on a shared sample tick and serializes the qualified
// press/release events onto one valid/ready port through a round-robin arbiter.
module button_event_ctrl #(
    parameter int N_BTN        = 4,
    parameter int CLK_DIV      = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_BTN-1:0]    btn_in,
    output logic [N_BTN-1:0]    btn_level,
    button_event_ctrl_if.master evt
);
    localparam int IW = $clog2(N_BTN);
    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    logic [N_BTN-1:0] r_sync1, r_sync2;
    logic [CW-1:0]    r_cnt;
    logic             w_tick;
    logic [1:0]       r_state [N_BTN];
    logic [SW-1:0]    r_stab  [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_pend, r_ptype;
    logic [N_BTN-1:0] w_post, w_postType, w_clr, w_drop;
    logic             r_valid, r_press, r_drop;
    logic [IW-1:0]    r_id, r_rr, w_pick;
    logic             w_found, w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

    // A post fires on the tick that completes the stable window of a check state.
    always_comb begin
        w_post     = '0;
        w_postType = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_postType[i] = (r_state[i] == ST_PRESS_CHK);
            w_post[i] = w_tick && (r_stab[i] == SW'(STABLE_TICKS - 1)) &&
                        (((r_state[i] == ST_PRESS_CHK)   &&  r_sync2[i]) ||
                         ((r_state[i] == ST_RELEASE_CHK) && !r_sync2[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= ST_RELEASED;
                r_stab[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                case (r_state[i])
                    ST_RELEASED: if (r_sync2[i]) begin
                        r_state[i] <= ST_PRESS_CHK;
                        r_stab[i]  <= '0;
                    end
                    ST_PRESS_CHK: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= ST_RELEASED;
                        end else if (w_post[i]) begin
                            r_state[i] <= ST_PRESSED;
                            r_level[i] <= 1'b1;
                        end else if (w_tick) begin
                            r_stab[i]  <= r_stab[i] + 1'b1;
                        end
                    end
                    ST_PRESSED: if (!r_sync2[i]) begin
                        r_state[i] <= ST_RELEASE_CHK;
                        r_stab[i]  <= '0;
                    end
                    default: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= ST_PRESSED;
                        end else if (w_post[i]) begin
                            r_state[i] <= ST_RELEASED;
                            r_level[i] <= 1'b0;
                        end else if (w_tick) begin
                            r_stab[i]  <= r_stab[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Round-robin: the first pending button after the last one served wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            for (int j = 0; j < N_BTN; j++) begin
                if (!w_found && r_pend[j] && (j == (int'(r_rr) + k) % N_BTN)) begin
                    w_found = 1'b1;
                    w_pick  = IW'(j);
                end
            end
        end
    end

    assign w_load = !r_valid || evt.evt_ready;

    always_comb begin
        w_clr  = '0;
        w_drop = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_clr[i]  = w_load && w_found && (w_pick == IW'(i));
            w_drop[i] = w_post[i] && r_pend[i] && !w_clr[i];
        end
    end

    // A post in the cycle its pend bit is loaded re-arms the bit, so nothing is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_ptype <= '0;
            r_drop  <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (w_post[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_ptype[i] <= w_postType[i];
                end else if (w_clr[i]) begin
                    r_pend[i]  <= 1'b0;
                end
            end
            r_drop <= |w_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_press <= 1'b0;
            r_rr    <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_id    <= w_pick;
                r_press <= r_ptype[w_pick];
                r_rr    <= w_pick;
            end
        end
    end

    assign btn_level     = r_level;
    assign evt.evt_valid = r_valid;
    assign evt.evt_id    = r_id;
    assign evt.evt_press = r_press;
    assign evt.evt_drop  = r_drop;
endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: directed button sequences push expected
// events into a queue, and an independent monitor pops them at each handshake.
module tb_button_event_ctrl;
    localparam int N_BTN = 4;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;

    button_event_ctrl_if #(.N_BTN(N_BTN)) evtIf ();

    button_event_ctrl #(
        .N_BTN(N_BTN),
        .CLK_DIV(4),
        .STABLE_TICKS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .evt(evtIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int dropCount = 0;
    int eventCount = 0;
    logic [2:0] sbQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] value);
        @(posedge clk);
        #1;
        btn_in = value;
    endtask

    task automatic waitLevel(input int idx, input logic value, input int maxCycles, input string name);
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (btn_level[idx] == value) break;
        end
        checkOutput(name, btn_level[idx], value);
    endtask

    task automatic waitDrain(input string name);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !evtIf.evt_valid) break;
        end
        checkOutput(name, sbQ.size(), 0);
    endtask

    task automatic setReady(input logic value);
        @(posedge clk);
        #1;
        evtIf.evt_ready = value;
    endtask

    // Monitor: every accepted event must match the oldest expected entry.
    initial begin
        logic [2:0] expEvt;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (evtIf.evt_drop) dropCount++;
                if (evtIf.evt_valid && evtIf.evt_ready) begin
                    eventCount++;
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_event actual id=%0d press=%0d required=none",
                                 evtIf.evt_id, evtIf.evt_press);
                    end else begin
                        expEvt = sbQ.pop_front();
                        checkOutput("sb_evt_id", 32'(evtIf.evt_id), 32'(expEvt[2:1]));
                        checkOutput("sb_evt_press", 32'(evtIf.evt_press), 32'(expEvt[0]));
                    end
                end
            end
        end
    end

    initial begin
        logic sawHigh;
        logic stallBad;
        int   base;
        int   b2b;

        rst_n = 1'b0;
        btn_in = '0;
        evtIf.evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_level", btn_level, 0);
        checkOutput("rst_valid", evtIf.evt_valid, 0);
        checkOutput("rst_id", evtIf.evt_id, 0);
        checkOutput("rst_drop", evtIf.evt_drop, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] clean press on button 2");
        sbQ.push_back({2'd2, 1'b1});
        applyStimulus(4'b0100);
        waitLevel(2, 1'b1, 40, "t1_level_rise");
        checkOutput("t1_valid_before", evtIf.evt_valid, 0);
        @(negedge clk);
        checkOutput("t1_valid", evtIf.evt_valid, 1);
        @(negedge clk);
        checkOutput("t1_valid_one_cycle", evtIf.evt_valid, 0);
        sbQ.push_back({2'd2, 1'b0});
        applyStimulus(4'b0000);
        waitLevel(2, 1'b0, 40, "t1_level_fall");
        waitDrain("t1_drain");

        $display("[TB] bouncing button 0");
        sawHigh = 1'b0;
        base = eventCount;
        for (int c = 0; c < 40; c++) begin
            applyStimulus({3'b000, ((c / 3) % 2 == 0)});
            @(negedge clk);
            if (btn_level[0]) sawHigh = 1'b1;
        end
        applyStimulus(4'b0000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (btn_level[0]) sawHigh = 1'b1;
        end
        checkOutput("t2_no_level", sawHigh, 0);
        checkOutput("t2_no_event", eventCount - base, 0);
        sbQ.push_back({2'd0, 1'b1});
        applyStimulus(4'b0001);
        waitLevel(0, 1'b1, 40, "t2_press_level");
        repeat (4) @(negedge clk);
        sbQ.push_back({2'd0, 1'b0});
        applyStimulus(4'b0000);
        waitLevel(0, 1'b0, 40, "t2_release_level");
        waitDrain("t2_drain");

        $display("[TB] simultaneous presses with stalled consumer");
        setReady(1'b0);
        sbQ.push_back({2'd1, 1'b1});
        sbQ.push_back({2'd3, 1'b1});
        sbQ.push_back({2'd0, 1'b1});
        applyStimulus(4'b1011);
        stallBad = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (evtIf.evt_valid && evtIf.evt_id != 2'd1) stallBad = 1'b1;
        end
        checkOutput("t3_levels", btn_level, 4'b1011);
        checkOutput("t3_stall_valid", evtIf.evt_valid, 1);
        checkOutput("t3_stall_id", evtIf.evt_id, 1);
        checkOutput("t3_stall_hold", stallBad, 0);
        setReady(1'b1);
        b2b = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (evtIf.evt_valid) b2b++;
        end
        checkOutput("t3_back_to_back", b2b, 3);
        @(negedge clk);
        checkOutput("t3_idle", evtIf.evt_valid, 0);
        sbQ.push_back({2'd1, 1'b0});
        sbQ.push_back({2'd3, 1'b0});
        sbQ.push_back({2'd0, 1'b0});
        applyStimulus(4'b0000);
        waitLevel(1, 1'b0, 40, "t3_release_level");
        waitDrain("t3_drain");

        $display("[TB] overwrite of pending event on button 1");
        setReady(1'b0);
        sbQ.push_back({2'd0, 1'b1});
        sbQ.push_back({2'd1, 1'b0});
        sbQ.push_back({2'd0, 1'b0});
        applyStimulus(4'b0001);
        waitLevel(0, 1'b1, 40, "t4_btn0_level");
        repeat (2) @(negedge clk);
        base = dropCount;
        applyStimulus(4'b0011);
        waitLevel(1, 1'b1, 40, "t4_btn1_press");
        applyStimulus(4'b0001);
        waitLevel(1, 1'b0, 40, "t4_btn1_release");
        repeat (3) @(negedge clk);
        checkOutput("t4_drop_once", dropCount - base, 1);
        checkOutput("t4_hold_id", evtIf.evt_id, 0);
        checkOutput("t4_hold_press", evtIf.evt_press, 1);
        setReady(1'b1);
        repeat (4) @(negedge clk);
        applyStimulus(4'b0000);
        waitLevel(0, 1'b0, 40, "t4_btn0_release");
        waitDrain("t4_drain");

        $display("[TB] reset during activity");
        setReady(1'b0);
        applyStimulus(4'b1000);
        waitLevel(3, 1'b1, 40, "t5_btn3_level");
        repeat (2) @(negedge clk);
        checkOutput("t5_pre_valid", evtIf.evt_valid, 1);
        applyStimulus(4'b1100);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_level", btn_level, 0);
        checkOutput("t5_rst_valid", evtIf.evt_valid, 0);
        checkOutput("t5_rst_id", evtIf.evt_id, 0);
        checkOutput("t5_rst_press", evtIf.evt_press, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        evtIf.evt_ready = 1'b1;
        sbQ.push_back({2'd2, 1'b1});
        sbQ.push_back({2'd3, 1'b1});
        waitLevel(2, 1'b1, 40, "t5_requalify");
        checkOutput("t5_levels", btn_level, 4'b1100);
        repeat (4) @(negedge clk);
        sbQ.push_back({2'd2, 1'b0});
        sbQ.push_back({2'd3, 1'b0});
        applyStimulus(4'b0000);
        waitLevel(2, 1'b0, 40, "t5_release_level");
        waitDrain("t5_drain");

        checkOutput("sb_empty", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
